// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
//   - CSR addresses used on the CSR file write port
//   - mstatus bit positions touched on trap entry / mret
//   - machine interrupt cause codes (also their bit positions in mip/mie)
//   - trap_state_t: sequencer state encoding
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  typedef enum logic [2:0] {
    StIdle,
    StWEpc,
    StWCause,
    StWTval,
    StWStatus,
    StRStatus,
    StRedirect
  } trap_state_t;

endpackage

// File: rtl/irq_prio.sv
// Fixed-priority encoder for enabled machine interrupts.
//   pend  in   XLEN  mip & mie
//   valid out  1     any enabled interrupt pending
//   code  out  4     winning cause code: MEI beats MSI beats MTI
module irq_prio
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pend,
  output logic            valid,
  output logic [3:0]      code
);

  // Only bits 11/7/3 can ever be set, so a full OR-reduce equals "any of the three".
  assign valid = |pend;

  always_comb begin
    code = 4'd0;
    if (pend[IRQ_MEI]) begin
      code = IRQ_MEI;
    end else if (pend[IRQ_MSI]) begin
      code = IRQ_MSI;
    end else if (pend[IRQ_MTI]) begin
      code = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer between the pipeline and the CSR file.
// Accepts exception / mret / interrupt in IDLE, then performs the CSR updates one write
// per cycle and finishes with a one-cycle PC redirect.
//   clk, resetn                        clock, async active-low reset
//   exc_valid/exc_cause/exc_pc/exc_tval synchronous exception request
//   mret                               mret retiring
//   irq_ok, next_pc                    interrupt window and resume PC
//   irq_ext/irq_sw/irq_timer           level interrupt lines
//   mstatus_in/mie_in/mtvec_in/mepc_in current CSR values
//   mip_out                            pending vector (combinational)
//   csr_we/csr_waddr/csr_wdata         CSR file write port
//   busy, trap_taken                   stall and flush to the pipeline
//   redirect_valid/redirect_pc         fetch redirect
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          MTVEC_MODE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_ok,
  input  logic [XLEN-1:0] next_pc,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic [XLEN-1:0] mip_out,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            busy,
  output logic            trap_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_t     state;
  logic [XLEN-1:0] epc_q, cause_q, tval_q, status_q, target_q;

  logic            prio_valid;
  logic [3:0]      prio_code;
  logic            irq_pend;
  logic [XLEN-1:0] mtvec_base, irq_target, irq_cause;
  logic [XLEN-1:0] status_trap, status_mret;

  always_comb begin
    mip_out          = '0;
    mip_out[IRQ_MEI] = irq_ext;
    mip_out[IRQ_MTI] = irq_timer;
    mip_out[IRQ_MSI] = irq_sw;
  end

  irq_prio #(
    .XLEN(XLEN)
  ) u_irq_prio (
    .pend (mip_out & mie_in),
    .valid(prio_valid),
    .code (prio_code)
  );

  assign irq_pend = mstatus_in[MSTATUS_MIE] & prio_valid & irq_ok;

  always_comb begin
    mtvec_base = {mtvec_in[XLEN-1:2], 2'b00};
    irq_target = mtvec_base;
    if (MTVEC_MODE_EN && (mtvec_in[1:0] == 2'b01)) begin
      // Wraps modulo 2^XLEN by construction.
      irq_target = mtvec_base + {{(XLEN-6){1'b0}}, prio_code, 2'b00};
    end
    irq_cause = {1'b1, {(XLEN-5){1'b0}}, prio_code};

    status_trap                                = status_q;
    status_trap[MSTATUS_MPIE]                  = status_q[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]                   = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    status_mret                                = status_q;
    status_mret[MSTATUS_MIE]                   = status_q[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE]                  = 1'b1;
    status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= StIdle;
      epc_q          <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      status_q       <= '0;
      target_q       <= '0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      busy           <= 1'b0;
      trap_taken     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      trap_taken     <= 1'b0;
      redirect_valid <= 1'b0;
      csr_we         <= 1'b0;
      unique case (state)
        StIdle: begin
          busy <= 1'b0;
          // busy is still high in the cycle after REDIRECT; requests wait until it drops.
          if (!busy) begin
            if (exc_valid) begin
              epc_q      <= exc_pc;
              cause_q    <= {{(XLEN-4){1'b0}}, exc_cause};
              tval_q     <= exc_tval;
              status_q   <= mstatus_in;
              target_q   <= mtvec_base;
              trap_taken <= 1'b1;
              busy       <= 1'b1;
              state      <= StWEpc;
            end else if (mret) begin
              status_q   <= mstatus_in;
              target_q   <= mepc_in;
              trap_taken <= 1'b1;
              busy       <= 1'b1;
              state      <= StRStatus;
            end else if (irq_pend) begin
              epc_q      <= next_pc;
              cause_q    <= irq_cause;
              tval_q     <= '0;
              status_q   <= mstatus_in;
              target_q   <= irq_target;
              trap_taken <= 1'b1;
              busy       <= 1'b1;
              state      <= StWEpc;
            end
          end
        end
        StWEpc: begin
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MEPC;
          csr_wdata <= epc_q;
          state     <= StWCause;
        end
        StWCause: begin
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MCAUSE;
          csr_wdata <= cause_q;
          state     <= StWTval;
        end
        StWTval: begin
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MTVAL;
          csr_wdata <= tval_q;
          state     <= StWStatus;
        end
        StWStatus: begin
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MSTATUS;
          csr_wdata <= status_trap;
          state     <= StRedirect;
        end
        StRStatus: begin
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MSTATUS;
          csr_wdata <= status_mret;
          state     <= StRedirect;
        end
        StRedirect: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= target_q;
          state          <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exc_valid, mret, irq_ok, irq_ext, irq_sw, irq_timer;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, next_pc, mstatus_in, mie_in, mtvec_in, mepc_in;
  logic [31:0] mip_out, csr_wdata, redirect_pc;
  logic [11:0] csr_waddr;
  logic        csr_we, busy, trap_taken, redirect_valid;

  int n_vec = 0;
  int n_err = 0;

  trap_ctrl #(
    .XLEN         (32),
    .MTVEC_MODE_EN(1'b1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .exc_pc        (exc_pc),
    .exc_tval      (exc_tval),
    .mret          (mret),
    .irq_ok        (irq_ok),
    .next_pc       (next_pc),
    .irq_ext       (irq_ext),
    .irq_sw        (irq_sw),
    .irq_timer     (irq_timer),
    .mstatus_in    (mstatus_in),
    .mie_in        (mie_in),
    .mtvec_in      (mtvec_in),
    .mepc_in       (mepc_in),
    .mip_out       (mip_out),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .busy          (busy),
    .trap_taken    (trap_taken),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ext, sw, tmr, ok, exc, mr;
    logic [3:0]  cause;
    logic [31:0] mstatus, mie, mtvec;
    logic        taken;
    logic [31:0] mip, epc, mcause, tval, status, target;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exc_valid  = 1'b0;
    mret       = 1'b0;
    irq_ok     = 1'b0;
    irq_ext    = 1'b0;
    irq_sw     = 1'b0;
    irq_timer  = 1'b0;
    exc_cause  = 4'd0;
    exc_pc     = 32'h40;
    exc_tval   = 32'hDEAD;
    next_pc    = 32'h80;
    mstatus_in = 32'h0;
    mie_in     = 32'h0;
    mtvec_in   = 32'h100;
    mepc_in    = 32'h44;
  endtask

  // Garbage on every input after acceptance: the running sequence must not notice.
  task automatic scramble();
    exc_valid  = 1'b0;
    mret       = 1'b0;
    exc_cause  = 4'hA;
    exc_pc     = 32'h1234_5678;
    exc_tval   = 32'h0BAD_0BAD;
    next_pc    = 32'h5555_0000;
    mstatus_in = 32'hAAAA_AAAA;
    mtvec_in   = 32'h7777_7771;
    mepc_in    = 32'h9999_9999;
  endtask

  // Called in cycle N (trap_taken visible); checks N+1..N+6.
  task automatic expect_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] status,
                             input logic [31:0] target);
    tick();
    chk("epc_we", 32'(csr_we), 32'd1);
    chk("epc_addr", 32'(csr_waddr), 32'h341);
    chk("epc_data", csr_wdata, epc);
    tick();
    chk("cause_addr", 32'(csr_waddr), 32'h342);
    chk("cause_data", csr_wdata, cause);
    tick();
    chk("tval_addr", 32'(csr_waddr), 32'h343);
    chk("tval_data", csr_wdata, tval);
    tick();
    chk("status_we", 32'(csr_we), 32'd1);
    chk("status_addr", 32'(csr_waddr), 32'h300);
    chk("status_data", csr_wdata, status);
    tick();
    chk("redir_valid", 32'(redirect_valid), 32'd1);
    chk("redir_pc", redirect_pc, target);
    chk("redir_we", 32'(csr_we), 32'd0);
    chk("redir_addr_hold", 32'(csr_waddr), 32'h300);
    chk("redir_busy", 32'(busy), 32'd1);
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_redir", 32'(redirect_valid), 32'd0);
  endtask

  vec_t vecs[10];
  bit   got;

  initial begin
    // order: ext sw tmr ok exc mr cause mstatus mie mtvec | taken mip epc mcause tval status target
    vecs[0] = '{0, 0, 0, 1, 1, 0, 4'd2, 32'h8, 32'h0, 32'h100,
                1, 32'h0, 32'h40, 32'h2, 32'hDEAD, 32'h1880, 32'h100};
    vecs[1] = '{1, 0, 0, 1, 0, 0, 4'd0, 32'h8, 32'h800, 32'h201,
                1, 32'h800, 32'h80, 32'h8000000B, 32'h0, 32'h1880, 32'h22C};
    vecs[2] = '{0, 0, 1, 1, 0, 0, 4'd0, 32'h0, 32'h80, 32'h100,
                0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{0, 0, 1, 0, 0, 0, 4'd0, 32'h8, 32'h80, 32'h100,
                0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{1, 1, 0, 1, 1, 1, 4'd5, 32'h8, 32'h888, 32'h100,
                1, 32'h808, 32'h40, 32'h5, 32'hDEAD, 32'h1880, 32'h100};
    vecs[5] = '{0, 1, 1, 1, 0, 0, 4'd0, 32'h8, 32'h888, 32'h101,
                1, 32'h88, 32'h80, 32'h80000003, 32'h0, 32'h1880, 32'h10C};
    vecs[6] = '{0, 0, 1, 1, 0, 0, 4'd0, 32'h8, 32'h80, 32'h101,
                1, 32'h80, 32'h80, 32'h80000007, 32'h0, 32'h1880, 32'h11C};
    vecs[7] = '{1, 1, 0, 1, 0, 0, 4'd0, 32'h8, 32'h8, 32'h100,
                1, 32'h808, 32'h80, 32'h80000003, 32'h0, 32'h1880, 32'h100};
    vecs[8] = '{0, 0, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0, 32'h101,
                1, 32'h0, 32'h40, 32'hF, 32'hDEAD, 32'h1800, 32'h100};
    vecs[9] = '{1, 0, 0, 1, 0, 0, 4'd0, 32'hFFFFFFFF, 32'h800, 32'hFFFFFFFD,
                1, 32'h800, 32'h80, 32'h8000000B, 32'h0, 32'hFFFFFFF7, 32'h28};

    // Reset state, mip_out live during reset.
    idle_inputs();
    resetn  = 1'b0;
    irq_ext = 1'b1;
    #12;
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_taken", 32'(trap_taken), 32'd0);
    chk("rst_redir", 32'(redirect_valid), 32'd0);
    chk("rst_addr", 32'(csr_waddr), 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_mip", mip_out, 32'h800);
    irq_ext = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    foreach (vecs[i]) begin
      idle_inputs();
      irq_ext    = vecs[i].ext;
      irq_sw     = vecs[i].sw;
      irq_timer  = vecs[i].tmr;
      irq_ok     = vecs[i].ok;
      exc_valid  = vecs[i].exc;
      mret       = vecs[i].mr;
      exc_cause  = vecs[i].cause;
      mstatus_in = vecs[i].mstatus;
      mie_in     = vecs[i].mie;
      mtvec_in   = vecs[i].mtvec;
      #1;
      chk($sformatf("v%0d_mip", i), mip_out, vecs[i].mip);
      tick();
      chk($sformatf("v%0d_taken", i), 32'(trap_taken), 32'(vecs[i].taken));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].taken));
      if (vecs[i].taken) begin
        scramble();
        expect_trap(vecs[i].epc, vecs[i].mcause, vecs[i].tval, vecs[i].status,
                    vecs[i].target);
      end else begin
        tick();
        chk($sformatf("v%0d_idle_we", i), 32'(csr_we), 32'd0);
      end
      idle_inputs();
      tick();
    end

    // mret sequence.
    idle_inputs();
    mstatus_in = 32'h1880;
    mepc_in    = 32'h44;
    mret       = 1'b1;
    tick();
    chk("mret_taken", 32'(trap_taken), 32'd1);
    scramble();
    tick();
    chk("mret_we", 32'(csr_we), 32'd1);
    chk("mret_addr", 32'(csr_waddr), 32'h300);
    chk("mret_data", csr_wdata, 32'h1888);
    tick();
    chk("mret_redir", 32'(redirect_valid), 32'd1);
    chk("mret_pc", redirect_pc, 32'h44);
    chk("mret_busy_n2", 32'(busy), 32'd1);
    tick();
    chk("mret_busy_n3", 32'(busy), 32'd0);
    idle_inputs();
    tick();

    // Request raised while busy is ignored until the sequence ends, then taken.
    exc_valid = 1'b1;
    exc_cause = 4'd1;
    tick();
    chk("busyreq_taken", 32'(trap_taken), 32'd1);
    exc_valid  = 1'b0;
    mret       = 1'b1;
    mstatus_in = 32'h1880;
    mepc_in    = 32'h44;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("busyreq_ign_n%0d", k), 32'(trap_taken), 32'd0);
      if (k == 2) chk("busyreq_cause", csr_wdata, 32'h1);
      if (k == 5) chk("busyreq_redir", redirect_pc, 32'h100);
    end
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      got = trap_taken;
    end
    chk("busyreq_late_taken", 32'(got), 32'd1);
    mret = 1'b0;
    tick();
    chk("busyreq_mret_data", csr_wdata, 32'h1888);
    tick();
    chk("busyreq_mret_pc", redirect_pc, 32'h44);
    idle_inputs();
    tick();
    tick();

    // Reset during W_CAUSE aborts the sequence.
    exc_valid = 1'b1;
    exc_cause = 4'd3;
    tick();
    exc_valid = 1'b0;
    tick();
    tick();
    chk("mid_cause_addr", 32'(csr_waddr), 32'h342);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(csr_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(csr_waddr), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      got = got | redirect_valid | csr_we;
    end
    chk("mid_rst_quiet", 32'(got), 32'd0);
    resetn = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    exc_valid  = 1'b1;
    exc_cause  = 4'd4;
    mstatus_in = 32'h8;
    tick();
    chk("post_rst_taken", 32'(trap_taken), 32'd1);
    scramble();
    expect_trap(32'h40, 32'h4, 32'hDEAD, 32'h1880, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer that sits between the core pipeline and the CSR file. It accepts synchronous exceptions, interrupt lines and mret, then prioritises them. It performs the CSR updates one write per cycle over the CSR file's single write port (mepc, mcause, mtval, mstatus). It then issues a PC redirect to the trap vector, or to mepc for mret.

Parameters:
XLEN, 32, data/address width
MTVEC_MODE_EN, 1, 1 = honour mtvec[1:0]==1 vectored mode for interrupts; 0 = always direct

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
exc_valid  in  1  synchronous exception request; sampled only in IDLE
exc_cause  in  4  exception code (0-15)
exc_pc  in  XLEN  PC of faulting instruction
exc_tval  in  XLEN  bad address/instruction for mtval
mret  in  1  mret retiring; sampled only in IDLE
irq_ok  in  1  pipeline at instruction boundary; interrupt may be taken
next_pc  in  XLEN  PC to save in mepc for an interrupt
irq_ext, irq_sw, irq_timer  in  1 each  level interrupt lines
mstatus_in, mie_in, mtvec_in, mepc_in  in  XLEN each  current CSR values from CSR file
mip_out  out  XLEN  pending vector: bit11=ext, bit7=timer, bit3=sw; all other bits 0
csr_we  out  1  CSR write strobe
csr_waddr  out  12  CSR address
csr_wdata  out  XLEN  CSR write data
busy  out  1  high in any state other than IDLE; pipeline stalls
trap_taken  out  1  one-cycle pulse on acceptance of a trap or mret; pipeline flushes
redirect_valid  out  1  one-cycle pulse with redirect_pc
redirect_pc  out  XLEN  new fetch PC

Behaviour:
- Reset (async, resetn=0): state=IDLE; csr_we, busy, trap_taken and redirect_valid are 0; csr_waddr, csr_wdata and redirect_pc are 0; all latched registers are 0. Reset asserted mid-sequence aborts immediately, with no further writes.
- mip_out is combinational from the irq lines and valid in every state, including reset.
- irq_pend = mstatus_in[3] (MIE) & |(mip_out & mie_in) & irq_ok.
- Acceptance in IDLE, in priority order:
  - exc_valid beats mret, which beats irq_pend.
  - Among interrupts, ext (code 11) beats sw (3), which beats timer (7).
- On acceptance the block latches:
  - epc: exc_pc, or next_pc for an interrupt.
  - cause: {0, exc_cause}, or {1'b1, 27'b0, code} for an interrupt.
  - tval: exc_tval for an exception, 0 for an interrupt.
  - mstatus_in.
  - target:
    - exception: mtvec_in & ~3.
    - interrupt with MTVEC_MODE_EN=1 and mtvec_in[1:0]==1: (mtvec_in & ~3) + 4*code.
    - mret: mepc_in.
  - trap_taken=1 for that cycle.
  - Later changes to the inputs have no effect on the sequence.
- Trap state sequence (IDLE on acceptance, N = acceptance cycle):
  - W_EPC, cycle N+1: we=1, addr 0x341, data=epc.
  - W_CAUSE, N+2: addr 0x342, data=cause.
  - W_TVAL, N+3: addr 0x343, data=tval.
  - W_STATUS, N+4: addr 0x300, data=mstatus with MPIE(bit7)←MIE(bit3), MIE←0, MPP[12:11]←2'b11.
  - REDIRECT, N+5: redirect_valid=1, redirect_pc=target, we=0.
  - IDLE at N+6.
- mret state sequence:
  - R_STATUS, N+1: addr 0x300, data=mstatus with MIE←MPIE, MPIE←1, MPP←2'b11.
  - REDIRECT, N+2: as above.
  - IDLE at N+3.
- Request handling while busy:
  - exc_valid, mret and interrupts are ignored while busy.
  - Requesters hold their request until they see trap_taken.
  - Irq lines are level-sensitive and are re-evaluated in IDLE.
- Outputs are registered.
  - csr_we and redirect_valid are 0 outside their states.
  - csr_waddr and csr_wdata hold their last value when csr_we=0.
- All arithmetic is XLEN-bit with wrap (vector add modulo 2^XLEN).
- Simultaneous events:
  - exc_valid together with an interrupt: the exception is taken and the interrupt stays pending.
  - An interrupt cannot be taken back-to-back, because W_STATUS clears MIE through the CSR file.

Decomposition:
- Package trap_pkg holds:
  - CSR address constants (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, MIP 0x344).
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - Interrupt codes (MSI=3, MTI=7, MEI=11).
  - State enum trap_state_t.
- One sub-module, irq_prio: combinational priority encoder from (mip & mie) to {valid, code[3:0]}.

Test Plan:
- Exception:
  - Stimulus: mtvec_in=0x100, mstatus_in=0x8, exc_valid, cause 2, exc_pc=0x40, tval=0xDEAD.
  - Response:
    - trap_taken at N.
    - Writes 0x341←0x40, 0x342←0x2, 0x343←0xDEAD, 0x300←0x1880 at N+1..N+4.
    - Redirect 0x100 at N+5.
- Vectored interrupt:
  - Stimulus: mtvec_in=0x201, mie_in=0x800, MIE=1, irq_ext=1, irq_ok=1, next_pc=0x80.
  - Response: mcause=0x8000000B, mtval=0, redirect 0x22C.
- Masking:
  - Stimulus: irq_timer=1, mie_in=0x80, first mstatus_in=0, then mstatus_in=0x8 with irq_ok=0.
  - Response: no trap in either case; mip_out=0x80.
- Priority:
  - Stimulus: exc_valid, mret, irq_ext and irq_sw all asserted, all enabled.
  - Response: exception path is taken; a request raised during busy is ignored.
- mret:
  - Stimulus: mstatus_in=0x1880, mepc_in=0x44.
  - Response: 0x300←0x1888 at N+1, redirect 0x44 at N+2, busy low at N+3.
- Reset mid-trap:
  - Stimulus: resetn=0 in W_CAUSE.
  - Response: csr_we=0 immediately, no redirect, IDLE after release; a fresh exception then runs a full sequence.
